// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FWFT FIFO controller for an external 256x16 EBR RAM.
//
// The 256-word RAM holds the body of the queue. A 2-entry prefetch buffer
// sits in front of it, so the total capacity is 258 words. The RAM has a
// one-cycle read latency, so a 1-bit in-flight flag tracks each issued read
// until its data is pushed into the buffer.
//
// Ports
//   clk_i        sole clock (also the RAM read/write clock)
//   rst_i        asynchronous, active-high reset
//   in_data_i    write-side data
//   in_valid_i   write request
//   in_ready_o   write-side space available (RAM not full)
//   out_data_o   head-of-FIFO data
//   out_valid_o  out_data_o is valid
//   out_ready_i  consumer accepts out_data_o
//   ram_waddr_o  RAM write address
//   ram_wdata_o  RAM write data (in_data_i)
//   ram_we_o     RAM write enable
//   ram_raddr_o  RAM read address
//   ram_re_o     RAM read enable
//   ram_rdata_i  RAM read data, valid the cycle after ram_re_o is sampled
//   ram_mask_o   RAM bit mask, constant 0 (all bits written)
//   level_o      (only with RAM_FIFO_LEVEL_EN) registered total occupancy, 0..258
//
// Build option: define RAM_FIFO_LEVEL_EN to add the level_o output.

module ram_fifo_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  ram_waddr_o,
  output logic [15:0] ram_wdata_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_raddr_o,
  output logic        ram_re_o,
  input  logic [15:0] ram_rdata_i,
  output logic [15:0] ram_mask_o
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [8:0]  level_o
`endif
);

  // Pointers carry a wrap bit so that full (256) and empty (0) differ.
  logic [8:0]  wp, rp, wp_n, rp_n;
  logic [8:0]  ram_cnt;
  logic        inflight;
  logic [1:0]  bcnt, bcnt_n;
  logic [15:0] buf0, buf1, buf0_n, buf1_n;
  logic        wr, pop, push;
  logic [2:0]  pend;

  assign ram_cnt     = wp - rp;
  assign in_ready_o  = (ram_cnt != 9'd256);
  assign wr          = in_valid_i & in_ready_o;
  assign out_valid_o = (bcnt != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = inflight;

  // Buffer slots that will be taken once the in-flight read lands, net of
  // this cycle's pop. pop implies bcnt >= 1, so this never underflows.
  assign pend     = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};
  assign ram_re_o = (ram_cnt != 9'd0) && (pend < 3'd2);

  assign ram_waddr_o = wp[7:0];
  assign ram_raddr_o = rp[7:0];
  assign ram_wdata_o = in_data_i;
  assign ram_we_o    = wr;
  assign ram_mask_o  = '0;
  assign out_data_o  = buf0;

  assign wp_n   = wp + {8'd0, wr};
  assign rp_n   = rp + {8'd0, ram_re_o};
  assign bcnt_n = bcnt + {1'b0, push} - {1'b0, pop};

  // buf0 is always the oldest entry; a pop shifts buf1 down.
  always_comb begin
    buf0_n = buf0;
    buf1_n = buf1;
    case ({push, pop})
      2'b10: begin
        if (bcnt == 2'd0) buf0_n = ram_rdata_i;
        else              buf1_n = ram_rdata_i;
      end
      2'b01: buf0_n = buf1;
      2'b11: begin
        if (bcnt == 2'd1) begin
          buf0_n = ram_rdata_i;
        end else begin
          buf0_n = buf1;
          buf1_n = ram_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
      bcnt     <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      wp       <= wp_n;
      rp       <= rp_n;
      inflight <= ram_re_o;
      bcnt     <= bcnt_n;
      buf0     <= buf0_n;
      buf1     <= buf1_n;
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  // Built from next-state values so level_o matches the state after each edge.
  logic [8:0] level_n;
  assign level_n = (wp_n - rp_n) + {8'd0, ram_re_o} + {7'd0, bcnt_n};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level_o <= '0;
    else       level_o <= level_n;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_rdata, ram_mask;
  logic        ram_we, ram_re;
`ifdef RAM_FIFO_LEVEL_EN
  logic [8:0]  level;
`endif

  ram_fifo_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ram_waddr_o (ram_waddr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_raddr_o (ram_raddr),
    .ram_re_o    (ram_re),
    .ram_rdata_i (ram_rdata),
    .ram_mask_o  (ram_mask)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level_o     (level)
`endif
  );

  always #5 clk = ~clk;

  // External 256x16 RAM with one-cycle registered read.
  logic [15:0] mem [256];
  logic [15:0] rdata_q = '0;
  assign ram_rdata = rdata_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rdata_q <= mem[ram_raddr];
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] q[$];
  int unsigned npush = 0;
  int unsigned npop  = 0;
  int unsigned mcnt  = 0;  // words held in RAM, as the bench sees it

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are evaluated at the falling edge: inputs and outputs are
  // stable until the next rising edge, where the transfers take effect.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_re) chk("no_read_when_ram_empty", 32'(mcnt != 0), 32'd1);
      if (ram_we) chk("no_write_when_ram_full", 32'(mcnt != 256), 32'd1);
      chk("in_ready_vs_ram_cnt", 32'(in_ready), 32'(mcnt != 256));
      chk("ram_mask", 32'(ram_mask), 32'd0);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        npush++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_with_empty_scoreboard", 32'd1, 32'd0);
        else chk("out_data", 32'(out_data), 32'(q.pop_front()));
        npop++;
      end
      mcnt = mcnt + (ram_we ? 1 : 0) - (ram_re ? 1 : 0);
    end
  end

  task automatic drain();
    int unsigned n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    chk("drained_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned p0, w0, cyc;

    // Reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single word latency
    in_data = 16'hA5A5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_after_N", 32'(out_valid), 32'd0);
    step();
    chk("lat_after_N1", 32'(out_valid), 32'd0);
    step();
    chk("lat_after_N2_valid", 32'(out_valid), 32'd1);
    chk("lat_after_N2_data", 32'(out_data), 32'hA5A5);
    drain();

    // Fill to 258 words with no reads
    for (int i = 0; i < 258; i++) begin
      in_data = 16'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 16'hDEAD;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("full_ignored_write_ready", 32'(in_ready), 32'd0);
    chk("full_accepted_count", 32'(q.size()), 32'd258);
`ifdef RAM_FIFO_LEVEL_EN
    chk("full_level", 32'(level), 32'd258);
`endif
    p0 = npop;
    drain();
    chk("full_drain_count", npop - p0, 32'd258);
    chk("after_drain_in_ready", 32'(in_ready), 32'd1);
`ifdef RAM_FIFO_LEVEL_EN
    chk("empty_level", 32'(level), 32'd0);
`endif

    // Sustained streaming: one word per cycle after a 3-edge start-up
    p0 = npop;
    w0 = npush;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_data = 16'(16'h1000 + i);
      step();
    end
    in_valid = 1'b0;
    chk("stream_writes", npush - w0, 32'd1000);
    chk("stream_pops", npop - p0, 32'd997);
    drain();

    // Random valid/ready traffic
    w0 = npush;
    cyc = 0;
    while ((npush - w0) < 5000 && cyc < 40000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_writes", npush - w0, 32'd5000);
    drain();

    // Reset with words queued and a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'(16'h7000 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_ram_re", 32'(ram_re), 32'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    in_data = 16'h1234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h1234);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 16-bit data and 8-bit RAM address to match the 256x16 EBR wrapper.
REQ-002 clk_i  input  1  sole clock; also drives the RAM's read and write clocks externally.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 in_data_i  input  16  write-side data.
REQ-005 in_valid_i  input  1  write request.
REQ-006 in_ready_o  output  1  write-side space available.
REQ-007 out_data_o  output  16  head-of-FIFO data.
REQ-008 out_valid_o  output  1  out_data_o is valid.
REQ-009 out_ready_i  input  1  consumer accepts out_data_o.
REQ-010 ram_waddr_o  output  8  RAM write address.
REQ-011 ram_wdata_o  output  16  RAM write data; equals in_data_i.
REQ-012 ram_we_o  output  1  RAM write enable; equals in_valid_i & in_ready_o.
REQ-013 ram_raddr_o  output  8  RAM read address.
REQ-014 ram_re_o  output  1  RAM read enable.
REQ-015 ram_rdata_i  input  16  RAM read data, valid on the cycle after the edge that sampled ram_re_o.
REQ-016 ram_mask_o  output  16  constant 16'h0000, meaning all bits written.

Function
REQ-017 Transfer rule: a transfer SHALL occur on a rising edge where valid & ready are both high, on either side.
REQ-018 Write pointer wp (9-bit with wrap bit): increments on each write transfer; ram_waddr_o = wp[7:0].
REQ-019 Read pointer rp (9-bit with wrap bit): increments on each issued read; ram_raddr_o = rp[7:0].
REQ-020 RAM occupancy: ram_cnt = wp - rp (0..256); in_ready_o SHALL be high exactly when ram_cnt != 256.
REQ-021 Output stage SHALL be a 2-entry prefetch buffer (FWFT), plus a 1-bit in-flight flag that is set on the edge after ram_re_o is high.
REQ-022 ram_re_o SHALL be high when ram_cnt != 0 and (buffer occupancy + in-flight − pop-this-cycle) < 2.
REQ-023 When in-flight is set, ram_rdata_i SHALL be pushed into the buffer on that edge.
REQ-024 out_valid_o SHALL be high when buffer occupancy != 0; out_data_o is the oldest entry.
REQ-025 Latency: a word written into an empty FIFO at edge N SHALL appear on out_valid_o/out_data_o after edge N+2.
REQ-026 Throughput: 1 word per cycle, sustained, with simultaneous write and read.
REQ-027 Total capacity: 258 words (256 RAM + 2 buffer).
REQ-028 Simultaneous write and read SHALL be legal at any level, with no address collision, because reads use only the registered ram_cnt.
REQ-029 Pointer wrap past 255 SHALL be seamless; data order is preserved.
REQ-030 Write attempts when full (in_ready_o low) and pops when empty (out_valid_o low) SHALL be ignored without state change.

Reset
REQ-031 On rst_i: wp=0, rp=0, buffer empty, in-flight cleared.
REQ-032 Output values in reset: in_ready_o=1, out_valid_o=0, out_data_o=0, ram_re_o=0.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight data; RAM contents are not cleared and are not visible afterwards.

Configuration
REQ-034 Macro RAM_FIFO_LEVEL_EN, when defined, SHALL add output level_o[8:0] = ram_cnt + in-flight + buffer occupancy (0..258), registered, reset 0.
REQ-035 When RAM_FIFO_LEVEL_EN is undefined, the level_o port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset, then write 16'hA5A5 with out_ready_i=0 -> out_valid_o rises 2 edges later, out_data_o=16'hA5A5.
REQ-037 Write 258 incrementing words 0..257 with no reads -> in_ready_o low after the 258th; a 259th write is ignored; level_o=258 when enabled.
REQ-038 From the full state, read all words -> sequence 0..257 in order; out_valid_o then low; in_ready_o high.
REQ-039 Continuous write and read of 1000 words with out_ready_i=1 -> after initial latency, one word per cycle, in order, across pointer wrap.
REQ-040 Random valid/ready toggling for 5000 words -> scoreboard matches; no RAM read when ram_cnt=0; no RAM write when ram_cnt=256.
REQ-041 Assert rst_i with 100 words queued and a read in flight -> out_valid_o=0 immediately, in_ready_o=1; the next word written is the next word output.
